// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the pipelined Wishbone slave memory.
// The response-queue entry carries the read data captured when the request was accepted.
package wb_mem_pkg;

   localparam int WORD_W = 32;
   localparam int WIDX_W = 10;
   localparam int BE_W   = WORD_W / 8;
   localparam int CNT_W  = 4;

   typedef struct packed {
      logic              is_read;
      logic [WORD_W-1:0] rdata;
      logic [CNT_W-1:0]  countdown;
   } wb_mem_entry_t;

   // Byte-lane merge used by the write port; lanes with be=0 keep their old contents.
   function automatic logic [WORD_W-1:0] byte_merge(
      input logic [WORD_W-1:0] old_word,
      input logic [WORD_W-1:0] new_word,
      input logic [BE_W-1:0]   lane_en
   );
      logic [WORD_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (lane_en[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/wb_resp_queue.sv
// In-order response queue: circular buffer of pending acks, each with its own latency countdown.
// The head becomes ready once its countdown has reached zero.
module wb_resp_queue
   import wb_mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  wb_mem_entry_t           push_entry,
   input  logic                    pop,
   input  logic                    flush,
   output logic                    head_ready,
   output logic                    head_read,
   output logic [WORD_W-1:0]       head_rdata,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   wb_mem_entry_t    slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
      end else if (flush) begin
         // Aborted cycle: drop every pending response, slot contents are don't-care.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (slots[i].countdown != '0) begin
               slots[i].countdown <= slots[i].countdown - CNT_W'(1);
            end
         end
         if (push) begin
            slots[wr_ptr] <= push_entry;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_ready = (count != '0) && (slots[rd_ptr].countdown == '0);
   assign head_read  = slots[rd_ptr].is_read;
   assign head_rdata = slots[rd_ptr].rdata;
   assign occupancy  = count;
   assign full       = (count == OCC_W'(DEPTH));

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone slave memory: accepts up to DEPTH outstanding requests and
// returns in-order acks LATENCY cycles after acceptance.
module wb_mem_slave
   import wb_mem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = WORD_W,
   parameter int MEM_WORDS = 1 << WIDX_W,
   parameter int LATENCY   = 2,
   parameter int DEPTH     = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cyc,
   input  logic                stb,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   data_out,
   output logic                ack,
   output logic                stall
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic [IDX_W-1:0]  word_idx;
   logic              accept;
   logic              unused_addr;
   wb_mem_entry_t     push_entry;
   logic              head_ready;
   logic              head_read;
   logic [DATA_W-1:0] head_rdata;
   logic [OCC_W-1:0]  occupancy;
   logic              full;

   // Sub-word offset and upper bits are don't-care, so the array aliases modulo MEM_WORDS*4.
   assign word_idx    = addr[IDX_W+1:2];
   assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

   // Stall is taken from registered occupancy only; a pop this cycle does not free a slot early.
   assign stall  = (occupancy == OCC_W'(DEPTH));
   assign accept = cyc & stb & ~full;

   always_ff @(posedge sys_clk) begin
      if (accept && we) begin
         mem[word_idx] <= byte_merge(mem[word_idx], data_in, be);
      end
   end

   // Read data is captured at acceptance, so it reflects every earlier accepted write.
   always_comb begin
      push_entry           = '0;
      push_entry.is_read   = ~we;
      push_entry.rdata     = we ? '0 : mem[word_idx];
      push_entry.countdown = CNT_W'(LATENCY - 1);
   end

   wb_resp_queue #(
      .DEPTH (DEPTH)
   ) u_resp_queue (
      .clk        (sys_clk),
      .rst_n      (sys_rst),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (head_ready),
      .flush      (~cyc),
      .head_ready (head_ready),
      .head_read  (head_read),
      .head_rdata (head_rdata),
      .occupancy  (occupancy),
      .full       (full)
   );

   assign ack      = head_ready;
   assign data_out = (head_ready && head_read) ? head_rdata : '0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed self-checking bench for wb_mem_slave: four instances with LATENCY 2, 8, 1 and 15.
module tb_wb_mem_slave;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [3:0]  cyc_v;
   logic        stb;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] dout [4];
   logic [3:0]  ack_v;
   logic [3:0]  stall_v;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      wb_mem_slave #(
         .ADDR_W    (32),
         .DATA_W    (32),
         .MEM_WORDS (1024),
         .LATENCY   ((g == 0) ? 2 : (g == 1) ? 8 : (g == 2) ? 1 : 15),
         .DEPTH     (4)
      ) u_dut (
         .sys_clk  (sys_clk),
         .sys_rst  (sys_rst),
         .cyc      (cyc_v[g]),
         .stb      (stb),
         .we       (we),
         .be       (be),
         .addr     (addr),
         .data_in  (data_in),
         .data_out (dout[g]),
         .ack      (ack_v[g]),
         .stall    (stall_v[g])
      );
   end

   function automatic logic [31:0] word_val(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0000_0111;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // One request on instance d, then wait for its ack and check latency and data.
   task automatic single(input int d, input int lat, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b,
                         input logic [31:0] exp, input string tag);
      int k;
      cyc_v[d] = 1'b1;
      stb      = 1'b1;
      we       = wr;
      addr     = a;
      data_in  = wd;
      be       = b;
      chk({tag, " stall"}, 32'(stall_v[d]), 32'd0);
      tick();
      stb = 1'b0;
      we  = 1'b0;
      k   = 0;
      while (ack_v[d] !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      chk({tag, " ack"}, 32'(ack_v[d]), 32'd1);
      chk({tag, " latency"}, k + 1, lat);
      chk({tag, " data"}, dout[d], exp);
      tick();
      chk({tag, " ack_drop"}, 32'(ack_v[d]), 32'd0);
      cyc_v[d] = 1'b0;
   endtask

   task automatic preload(input int d, input int lat, input int n);
      for (int i = 0; i < n; i++) begin
         single(d, lat, 1'b1, 32'(i * 4), word_val(i), 4'hF, 32'd0, $sformatf("pre%0d_%0d", d, i));
      end
   endtask

   // Stream n reads of words 0..n-1 with stb held, honouring stall.
   task automatic stream(input int d, input int n, input int lat, input bit full_chk, input string tag);
      int acc, acks, cnt, first, last, acc_at_first;
      bit take, gap;
      acc = 0; acks = 0; cnt = 0; first = -1; last = -1; acc_at_first = 0; gap = 1'b0;
      cyc_v[d] = 1'b1;
      stb      = 1'b1;
      we       = 1'b0;
      be       = 4'h0;
      addr     = 32'h0;
      while (acks < n && cnt < 300) begin
         take = stb && (stall_v[d] === 1'b0);
         if (ack_v[d] === 1'b1) begin
            chk($sformatf("%s data%0d", tag, acks), dout[d], word_val(acks));
            if (first < 0) begin
               first        = cnt;
               acc_at_first = acc;
            end else if (cnt != last + 1) begin
               gap = 1'b1;
            end
            last = cnt;
            acks++;
         end
         tick();
         cnt++;
         if (take) begin
            acc++;
            addr = 32'(acc * 4);
            if (acc == n) stb = 1'b0;
            if (full_chk && acc == 4) chk({tag, " stall_full"}, 32'(stall_v[d]), 32'd1);
         end
      end
      chk({tag, " ack_count"}, acks, n);
      chk({tag, " accepted"}, acc, n);
      chk({tag, " first_latency"}, first, lat);
      if (full_chk) chk({tag, " accepted_before_ack"}, acc_at_first, 32'd4);
      else          chk({tag, " gapless"}, 32'(gap), 32'd0);
      cyc_v[d] = 1'b0;
      tick();
      chk({tag, " idle_ack"}, 32'(ack_v[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack;
      sys_rst = 1'b1;
      cyc_v   = 4'h0;
      stb     = 1'b0;
      we      = 1'b0;
      be      = 4'h0;
      addr    = 32'h0;
      data_in = 32'h0;
      #3 sys_rst = 1'b0;
      #1;
      chk("rst ack", 32'(ack_v), 32'd0);
      chk("rst stall", 32'(stall_v), 32'd0);
      chk("rst data_out", dout[0], 32'd0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      tick();

      // write then read, LATENCY 2
      single(0, 2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr10");
      single(0, 2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, "rd10");

      // byte-enable merge, be=0 write, sub-word offset
      single(0, 2, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 32'h0, "wr_base");
      single(0, 2, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0, "wr_be5");
      single(0, 2, 1'b0, 32'h10, 32'h0, 4'hF, 32'h11BB_33DD, "rd_merge");
      single(0, 2, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, "wr_be0");
      single(0, 2, 1'b0, 32'h13, 32'h0, 4'h0, 32'h11BB_33DD, "rd_be0_off3");

      // address wrap
      single(0, 2, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, "wr0");
      single(0, 2, 1'b0, 32'h1000, 32'h0, 4'h0, 32'hCAFE_F00D, "rd_wrap");
      single(0, 2, 1'b0, 32'hFFFF_F010, 32'h0, 4'h0, 32'h11BB_33DD, "rd_upper");

      // write immediately followed by read of the same word
      cyc_v[0] = 1'b1;
      stb      = 1'b1;
      we       = 1'b1;
      addr     = 32'h20;
      data_in  = 32'h0BAD_C0DE;
      be       = 4'hF;
      tick();
      we = 1'b0;
      tick();
      stb = 1'b0;
      chk("raw wr_ack", 32'(ack_v[0]), 32'd1);
      chk("raw wr_data", dout[0], 32'h0);
      tick();
      chk("raw rd_ack", 32'(ack_v[0]), 32'd1);
      chk("raw rd_data", dout[0], 32'h0BAD_C0DE);
      tick();
      chk("raw idle", 32'(ack_v[0]), 32'd0);
      cyc_v[0] = 1'b0;
      tick();

      // latency sweep and streams
      preload(2, 1, 6);
      stream(2, 6, 1, 1'b0, "l1");
      preload(3, 15, 4);
      stream(3, 4, 15, 1'b0, "l15");
      preload(1, 8, 6);
      stream(1, 6, 8, 1'b1, "full");

      // abort with a write and two reads outstanding
      cyc_v[3] = 1'b1;
      stb      = 1'b1;
      we       = 1'b1;
      addr     = 32'h18;
      data_in  = 32'h5A5A_A5A5;
      be       = 4'hF;
      tick();
      we   = 1'b0;
      addr = 32'h0;
      tick();
      addr = 32'h4;
      tick();
      stb      = 1'b0;
      cyc_v[3] = 1'b0;
      n_ack    = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ack_v[3] === 1'b1) n_ack++;
      end
      chk("abort acks", n_ack, 32'd0);
      chk("abort stall", 32'(stall_v[3]), 32'd0);
      single(3, 15, 1'b0, 32'h18, 32'h0, 4'h0, 32'h5A5A_A5A5, "abort_commit");
      single(3, 15, 1'b0, 32'h4, 32'h0, 4'h0, word_val(1), "abort_after");

      // reset with requests in flight
      cyc_v = 4'b0011;
      stb   = 1'b1;
      we    = 1'b0;
      addr  = 32'h0;
      for (int i = 0; i < 4; i++) tick();
      chk("prerst ack", 32'(ack_v[0]), 32'd1);
      chk("prerst data", dout[0], 32'hCAFE_F00D);
      chk("prerst stall", 32'(stall_v[1]), 32'd1);
      sys_rst = 1'b0;
      #1;
      chk("midrst ack", 32'(ack_v[0]), 32'd0);
      chk("midrst data", dout[0], 32'd0);
      chk("midrst stall", 32'(stall_v[1]), 32'd0);
      stb = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      n_ack   = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack_v[1:0] !== 2'b00) n_ack++;
      end
      chk("postrst stale_acks", n_ack, 32'd0);
      cyc_v = 4'h0;
      tick();
      single(1, 8, 1'b0, 32'h8, 32'h0, 4'h0, word_val(2), "postrst_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
